// File: rtl/warblade_pkg.sv
// Shared types for the missile path: coordinate type, parked coordinate, slot state.
package warblade_pkg;
   typedef logic [10:0] coord_t;
   localparam coord_t PARK = 11'h7FF;
   typedef enum logic {IDLE = 1'b0, FLY = 1'b1} slot_state_t;
endpackage

// File: rtl/missile_slot.sv
// One missile slot: IDLE/FLY state plus x/y registers, frame-tick movement and retire.
module missile_slot
   import warblade_pkg::*;
#(
   parameter int SPEED = 8,
   parameter int TOP_Y = 0
) (
   input  logic   pclk,
   input  logic   rst_n,
   input  logic   launch,
   input  logic   tick,
   input  logic   retire,
   input  coord_t x_init,
   input  coord_t y_init,
   output coord_t xpos,
   output coord_t ypos,
   output logic   missile_on
);
   localparam coord_t SPEED_C = coord_t'(SPEED);
   localparam coord_t TOP_LIM = coord_t'(TOP_Y + SPEED);

   slot_state_t state_q, state_d;
   coord_t      x_d, y_d;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         xpos    <= PARK;
         ypos    <= PARK;
      end else begin
         state_q <= state_d;
         xpos    <= x_d;
         ypos    <= y_d;
      end
   end

   // Compare before subtracting so y never wraps past the top.
   always_comb begin
      state_d = state_q;
      x_d     = xpos;
      y_d     = ypos;
      case (state_q)
         IDLE: if (launch && !retire) begin
            state_d = FLY;
            x_d     = x_init;
            y_d     = y_init;
         end
         FLY: if (retire || (tick && ypos < TOP_LIM)) begin
            state_d = IDLE;
            x_d     = PARK;
            y_d     = PARK;
         end else if (tick) begin
            y_d = ypos - SPEED_C;
         end
         default: state_d = IDLE;
      endcase
   end

   assign missile_on = (state_q == FLY);
endmodule

// File: rtl/ship_missile_ctl.sv
// Fire detection, slot allocation and launch cooldown for the ship's two missiles.
// Optional MISSILE_AUTOFIRE_EN: a held fire button requests a launch every cycle.
module ship_missile_ctl
   import warblade_pkg::*;
#(
   parameter int SPEED        = 8,
   parameter int COOLDOWN     = 10,
   parameter int SPAWN_OFFSET = 10,
   parameter int TOP_Y        = 0
) (
   input  logic   pclk,
   input  logic   rst_n,
   input  logic   fire,
   input  logic   frame_tick,
   input  logic   level_change,
   input  coord_t xpos_ship,
   input  coord_t ypos_ship,
   input  logic   kill_1,
   input  logic   kill_2,
   output coord_t xpos_missile_1,
   output coord_t ypos_missile_1,
   output coord_t xpos_missile_2,
   output coord_t ypos_missile_2,
   output logic   missile_on_1,
   output logic   missile_on_2
);
   localparam coord_t     SPAWN_C   = coord_t'(SPAWN_OFFSET);
   localparam coord_t     SPAWN_LIM = coord_t'(SPAWN_OFFSET + TOP_Y);
   localparam logic [7:0] CD_INIT   = 8'(COOLDOWN);

   logic [7:0] cd;
   logic       req, accept, launch_1, launch_2, alloc_kill;
   logic       retire_1, retire_2;
   coord_t     spawn_y;

`ifdef MISSILE_AUTOFIRE_EN
   assign req = fire;
`else
   logic fire_q;
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) fire_q <= 1'b0;
      else        fire_q <= fire;
   end
   assign req = fire & ~fire_q;
`endif

   assign retire_1 = kill_1 | level_change;
   assign retire_2 = kill_2 | level_change;

   // A launch into a slot that is being retired this cycle is dropped outright.
   assign alloc_kill = missile_on_1 ? retire_2 : retire_1;
   assign accept     = req && (cd == 8'd0) && !(missile_on_1 && missile_on_2)
                       && (ypos_ship >= SPAWN_LIM) && !alloc_kill;
   assign launch_1   = accept & ~missile_on_1;
   assign launch_2   = accept &  missile_on_1;
   assign spawn_y    = ypos_ship - SPAWN_C;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n)                       cd <= 8'd0;
      else if (accept)                  cd <= CD_INIT;
      else if (frame_tick && cd != 8'd0) cd <= cd - 8'd1;
   end

   missile_slot #(.SPEED(SPEED), .TOP_Y(TOP_Y)) u_slot_1 (
      .pclk(pclk), .rst_n(rst_n), .launch(launch_1), .tick(frame_tick),
      .retire(retire_1), .x_init(xpos_ship), .y_init(spawn_y),
      .xpos(xpos_missile_1), .ypos(ypos_missile_1), .missile_on(missile_on_1)
   );

   missile_slot #(.SPEED(SPEED), .TOP_Y(TOP_Y)) u_slot_2 (
      .pclk(pclk), .rst_n(rst_n), .launch(launch_2), .tick(frame_tick),
      .retire(retire_2), .x_init(xpos_ship), .y_init(spawn_y),
      .xpos(xpos_missile_2), .ypos(ypos_missile_2), .missile_on(missile_on_2)
   );
endmodule

// File: tb/tb_ship_missile_ctl.sv
// Randomized self-checking bench for ship_missile_ctl against a per-cycle behavioural model.
module tb_ship_missile_ctl;
   localparam int SPEED = 8, COOLDOWN = 10, SPAWN_OFFSET = 10, TOP_Y = 0;

   logic        pclk = 0, rst_n = 0;
   logic        fire = 0, frame_tick = 0, level_change = 0, kill_1 = 0, kill_2 = 0;
   logic [10:0] xpos_ship = 0, ypos_ship = 0;
   logic [10:0] xpos_missile_1, ypos_missile_1, xpos_missile_2, ypos_missile_2;
   logic        missile_on_1, missile_on_2;

   int tests = 0, errors = 0;
   int m_on[2], m_x[2], m_y[2], m_cd, launches_seen;
   bit m_fp, prev_on1, prev_on2;

   ship_missile_ctl #(.SPEED(SPEED), .COOLDOWN(COOLDOWN), .SPAWN_OFFSET(SPAWN_OFFSET), .TOP_Y(TOP_Y)) dut (
      .pclk(pclk), .rst_n(rst_n), .fire(fire), .frame_tick(frame_tick),
      .level_change(level_change), .xpos_ship(xpos_ship), .ypos_ship(ypos_ship),
      .kill_1(kill_1), .kill_2(kill_2),
      .xpos_missile_1(xpos_missile_1), .ypos_missile_1(ypos_missile_1),
      .xpos_missile_2(xpos_missile_2), .ypos_missile_2(ypos_missile_2),
      .missile_on_1(missile_on_1), .missile_on_2(missile_on_2)
   );

   always #5 pclk = ~pclk;

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin m_on[i] = 0; m_x[i] = 0; m_y[i] = 0; end
      m_cd = 0; m_fp = 0; prev_on1 = 0; prev_on2 = 0;
   endtask

   task automatic chk(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Spec-level model: one frame of slot rules applied to the pre-edge state.
   task automatic model_step(input bit f, t, l, k1, k2, input int xs, ys);
      bit req, acc, k[2];
      int s;
`ifdef MISSILE_AUTOFIRE_EN
      req = f;
`else
      req = f && !m_fp;
`endif
      m_fp = f;
      k[0] = k1; k[1] = k2;
      s = m_on[0] ? 1 : 0;
      acc = req && m_cd == 0 && !(m_on[0] && m_on[1]) && ys >= SPAWN_OFFSET + TOP_Y && !l && !k[s];
      for (int i = 0; i < 2; i++)
         if (m_on[i]) begin
            if (k[i] || l) m_on[i] = 0;
            else if (t) begin
               if (m_y[i] < TOP_Y + SPEED) m_on[i] = 0;
               else m_y[i] -= SPEED;
            end
         end
      if (acc) begin
         m_on[s] = 1; m_x[s] = xs; m_y[s] = ys - SPAWN_OFFSET; m_cd = COOLDOWN;
      end else if (t && m_cd > 0) m_cd--;
   endtask

   task automatic check_outputs();
      int ex1, ey1, ex2, ey2;
      ex1 = m_on[0] ? m_x[0] : 2047; ey1 = m_on[0] ? m_y[0] : 2047;
      ex2 = m_on[1] ? m_x[1] : 2047; ey2 = m_on[1] ? m_y[1] : 2047;
      tests++;
      if (xpos_missile_1 != 11'(ex1) || ypos_missile_1 != 11'(ey1) || missile_on_1 != m_on[0][0] ||
          xpos_missile_2 != 11'(ex2) || ypos_missile_2 != 11'(ey2) || missile_on_2 != m_on[1][0]) begin
         errors++;
         $display("FAIL model t=%0t: got s1=(%0d,%0d,%0d) s2=(%0d,%0d,%0d) expected s1=(%0d,%0d,%0d) s2=(%0d,%0d,%0d)",
                  $time, xpos_missile_1, ypos_missile_1, missile_on_1, xpos_missile_2, ypos_missile_2, missile_on_2,
                  ex1, ey1, m_on[0], ex2, ey2, m_on[1]);
      end
      if (missile_on_1 && !prev_on1) launches_seen++;
      if (missile_on_2 && !prev_on2) launches_seen++;
      prev_on1 = missile_on_1; prev_on2 = missile_on_2;
   endtask

   task automatic step(input bit f, t, l, k1, k2, input int xs, ys);
      @(negedge pclk);
      fire = f; frame_tick = t; level_change = l; kill_1 = k1; kill_2 = k2;
      xpos_ship = 11'(xs); ypos_ship = 11'(ys);
      model_step(f, t, l, k1, k2, xs, ys);
      @(posedge pclk); #1;
      check_outputs();
   endtask

   task automatic do_reset();
      @(negedge pclk);
      rst_n = 0; fire = 0; frame_tick = 0; level_change = 0; kill_1 = 0; kill_2 = 0;
      model_reset();
      repeat (2) @(negedge pclk);
      rst_n = 1;
   endtask

   initial begin
      model_reset();
      do_reset();
      #1;
      chk("reset_x1", xpos_missile_1, 2047); chk("reset_y2", ypos_missile_2, 2047);
      chk("reset_on", {missile_on_1, missile_on_2}, 0);

      step(1, 0, 0, 0, 0, 400, 550);
      chk("launch_x1", xpos_missile_1, 400); chk("launch_y1", ypos_missile_1, 540);
      chk("launch_on1", missile_on_1, 1); chk("launch_y2_park", ypos_missile_2, 2047);
      step(0, 0, 0, 0, 0, 400, 550);
      repeat (3) step(0, 1, 0, 0, 0, 400, 550);
      chk("three_ticks_y1", ypos_missile_1, 516);
      repeat (2) step(0, 1, 0, 0, 0, 400, 550);
      step(1, 0, 0, 0, 0, 400, 550);
      chk("cooldown_drop", missile_on_2, 0);
      step(0, 0, 0, 0, 0, 400, 550);
      repeat (5) step(0, 1, 0, 0, 0, 400, 550);
      step(1, 0, 0, 0, 0, 300, 550);
      chk("slot2_launch_on", missile_on_2, 1); chk("slot2_launch_x", xpos_missile_2, 300);
      step(0, 0, 0, 0, 0, 300, 550);
      step(1, 0, 0, 0, 0, 300, 550);
      chk("both_busy_y1", ypos_missile_1, 460);
      step(0, 1, 0, 1, 0, 300, 550);
      chk("kill1_on1", missile_on_1, 0); chk("kill1_x1_park", xpos_missile_1, 2047);
      chk("kill1_slot2_move", ypos_missile_2, 532);
      repeat (10) step(0, 1, 0, 0, 0, 300, 550);
      step(1, 0, 1, 0, 0, 300, 550);
      chk("lvl_fire_on", {missile_on_1, missile_on_2}, 0);
      step(0, 0, 0, 0, 0, 300, 550);
      step(1, 0, 0, 0, 0, 100, 30);
      chk("post_lvl_launch_y", ypos_missile_1, 20);
      step(0, 0, 0, 0, 0, 100, 30);
      repeat (2) step(0, 1, 0, 0, 0, 100, 30);
      chk("near_top_y", ypos_missile_1, 4);
      step(0, 1, 0, 0, 0, 100, 30);
      chk("top_retire_on", missile_on_1, 0); chk("top_retire_y", ypos_missile_1, 2047);

      // Asynchronous reset in mid-flight.
      repeat (11) step(0, 1, 0, 0, 0, 100, 600);
      step(1, 0, 0, 0, 0, 100, 600);
      step(0, 1, 0, 0, 0, 100, 600);
      @(posedge pclk); #3;
      rst_n = 0; #1;
      chk("async_rst_on", {missile_on_1, missile_on_2}, 0);
      chk("async_rst_y1", ypos_missile_1, 2047);
      fire = 0; frame_tick = 0;
      model_reset();
      @(negedge pclk); rst_n = 1;

      // Held fire over 40 frame ticks.
      launches_seen = 0;
      for (int c = 0; c < 160; c++) step(1, (c % 4) == 3, 0, 0, 0, 500, 550);
`ifdef MISSILE_AUTOFIRE_EN
      chk("held_fire_launches", launches_seen, 2);
`else
      chk("held_fire_launches", launches_seen, 1);
`endif
      step(0, 0, 0, 0, 0, 500, 550);

      for (int c = 0; c < 4000; c++)
         step($urandom_range(99) < 30, $urandom_range(99) < 30, $urandom_range(99) < 2,
              $urandom_range(99) < 4, $urandom_range(99) < 4,
              $urandom_range(2047), ($urandom_range(9) == 0) ? $urandom_range(20) : $urandom_range(1100));

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
